// File: rtl/accum_sequencer.sv
// accum_sequencer: four-cycle fetch/decode/exec/writeback sequencer driving an
// 8-bit ALU, with an accumulator, zero flag, branches and register-file writes.
// Ports: clk, reset (sync, active-high), start/done handshake, imem_addr/imem_data
// (sync instruction memory), rf_raddr/rf_rdata, rf_we/rf_waddr/rf_wdata,
// alu_in1/alu_in2/s_or_c/shift_dir/op_in/alu_result, acc_q, cycle_cnt.
// Optional feature macro: CYCLE_CNT_EN builds the saturating run-cycle counter.
module accum_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [2:0]      rf_raddr,
  input  logic [7:0]      rf_rdata,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [7:0]      rf_wdata,
  output logic [7:0]      alu_in1,
  output logic [7:0]      alu_in2,
  output logic            s_or_c,
  output logic            shift_dir,
  output logic [3:0]      op_in,
  input  logic [7:0]      alu_result,
  output logic [7:0]      acc_q,
  output logic [15:0]     cycle_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [7:0]      acc;
  logic [7:0]      res;
  logic            zflag;

  logic is_s, is_c, is_b, is_m;
  logic is_li, is_st, is_ld, is_halt;
  logic go;
  logic running;
  logic [PC_W-1:0] br_off;

  assign is_s    = (ir[8:7] == 2'b11);
  assign is_c    = (ir[8:7] == 2'b10);
  assign is_b    = (ir[8:7] == 2'b01);
  assign is_m    = (ir[8:7] == 2'b00);
  assign is_li   = is_m && (ir[6:5] == 2'b00);
  assign is_st   = is_m && (ir[6:5] == 2'b01);
  assign is_ld   = is_m && (ir[6:5] == 2'b10);
  assign is_halt = is_m && (ir[6:5] == 2'b11);

  assign go      = start && (state == IDLE || state == HALT);
  assign running = (state == FETCH) || (state == DECODE) ||
                   (state == EXEC)  || (state == WB);

  // 7-bit branch displacement, sign-extended to the pc width
  assign br_off = {{(PC_W-7){ir[6]}}, ir[6:0]};

  assign imem_addr = pc;
  assign rf_raddr  = ir[2:0];
  assign rf_waddr  = ir[2:0];
  assign rf_wdata  = acc;
  assign alu_in1   = acc;
  assign acc_q     = acc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = is_halt ? HALT : FETCH;
      HALT:    if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done      = (state == HALT);
    // reset in the WB cycle must keep the write from landing
    rf_we     = (state == WB) && is_st && !reset;
    s_or_c    = 1'b0;
    shift_dir = 1'b0;
    op_in     = 4'd0;
    alu_in2   = 8'd0;
    if (state == EXEC) begin
      unique case (1'b1)
        is_s: begin
          s_or_c    = 1'b1;
          shift_dir = ir[6];
          alu_in2   = {5'b0, ir[5:3]};
        end
        is_c: begin
          op_in   = ir[6:3];
          alu_in2 = rf_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      acc   <= 8'd0;
      ir    <= 9'd0;
      res   <= 8'd0;
      zflag <= 1'b0;
    end else if (go) begin
      pc    <= '0;
      acc   <= 8'd0;
      zflag <= 1'b0;
    end else begin
      unique case (state)
        DECODE: ir <= imem_data;
        EXEC:   res <= is_ld ? rf_rdata : alu_result;
        WB: begin
          if (is_s || is_c) begin
            acc   <= res;
            zflag <= (res == 8'd0);
          end
          if (is_li) acc <= {3'b0, ir[4:0]};
          if (is_ld) acc <= res;
          if (!is_halt) begin
            if (is_b && zflag) pc <= pc + br_off;
            else               pc <= pc + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 16'd0;
    else if (go)
      cnt_q <= 16'd0;
    else if (running && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  logic unused_running;
  assign unused_running = running;
  assign cycle_cnt      = 16'd0;
`endif

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Multi-cycle control sequencer that drives the 8-bit ALU and its operation-select logic. It fetches 9-bit instructions from a synchronous instruction memory and decodes them into the ALU select fields (`s_or_c`, `shift_dir`, `op_in`) plus the ALU operands. It captures the ALU result into an internal accumulator and drives register-file writes. It sits between the instruction memory/register file and the ALU, and answers a top-level `start`/`done` handshake.

## Interface
- `PC_W`, 8: program-counter and instruction-memory address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a program at address 0.
- `done`  out  1  high while in HALT.
- `imem_addr`  out  PC_W  instruction address; equals `pc`.
- `imem_data`  in  9  instruction; valid one cycle after `imem_addr`.
- `rf_raddr`  out  3  register-file read address, from `ir[2:0]`.
- `rf_rdata`  in  8  combinational read data.
- `rf_we`  out  1  register-file write strobe; one cycle wide.
- `rf_waddr`  out  3  write address.
- `rf_wdata`  out  8  write data; equals `acc`.
- `alu_in1`  out  8  equals `acc`.
- `alu_in2`  out  8  C-type: `rf_rdata`. S-type: `{5'b0, ir[5:3]}`.
- `s_or_c`  out  1  0 = C class, 1 = S class.
- `shift_dir`  out  1  0 = left, 1 = right.
- `op_in`  out  4  C-type operation code.
- `alu_result`  in  8  ALU output.
- `acc_q`  out  8  accumulator value, for debug.
- `cycle_cnt`  out  16  cycles spent running (see Configuration).

## Operation
- Instruction classes, selected by `ir[8:7]`:
  - 11, S-type: `acc <= acc` shifted by `ir[5:3]`; direction is `ir[6]`; bits `[2:0]` ignored.
  - 10, C-type: `acc <= acc op R[ir[2:0]]`; the operation is `ir[6:3]`, passed unchanged on `op_in`.
  - 01, B-type: if `zflag` is set, `pc <= pc + sext(ir[6:0])`; otherwise `pc <= pc + 1`.
  - 00, M-type, sub-selected by `ir[6:5]`:
    - 00, LI: `acc <= {3'b0, ir[4:0]}`.
    - 01, ST: `R[ir[2:0]] <= acc`.
    - 10, LD: `acc <= rf_rdata`.
    - 11, HALT.
- `zflag` updates only on S-type and C-type instructions: `zflag = (alu_result == 0)`. LI, LD, ST and B-type leave it unchanged.
- States:
  - IDLE: waiting; `start` → FETCH.
  - FETCH → DECODE: `imem_addr = pc`.
  - DECODE → EXEC: `ir <= imem_data`.
  - EXEC → WB: ALU fields driven; `res <= alu_result` (for LD, `res <= rf_rdata`).
  - WB → FETCH, or → HALT for a HALT instruction: `acc`, `zflag`, `pc` and `rf_we` are applied.
  - HALT: `done` = 1; `start` → FETCH.
- On `start` in IDLE or HALT, `pc`, `acc` and `zflag` clear to 0 and the next state is FETCH.
- `start` in any other state is ignored.
- Outside EXEC, `s_or_c`, `shift_dir` and `op_in` are held at 0, and `alu_in2` is 0.
- `pc` arithmetic is modulo 2^PC_W; wrap-around is silent in both directions.
- HALT does not advance `pc`.

## Timing
- Reset values:
  - State IDLE.
  - `pc`, `acc`, `ir`, `zflag`: 0.
  - `done`, `rf_we`, `s_or_c`, `shift_dir`: 0.
  - `op_in`, `cycle_cnt`: 0.
- Every instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB).
- The first FETCH occurs the cycle after `start` is sampled.
- `rf_we` is high only in the WB cycle of an ST instruction.
- `done` rises on the cycle after the WB of a HALT instruction.
- `reset` overrides `start` and everything else. Reset asserted during WB suppresses `rf_we` in that same cycle.

## Configuration
- `CYCLE_CNT_EN` defined:
  - `cycle_cnt` increments on every cycle spent in FETCH, DECODE, EXEC or WB.
  - It saturates at 16'hFFFF.
  - It clears on `start`.
- `CYCLE_CNT_EN` undefined: `cycle_cnt` is tied to 0 and no counter flops are built.

## Test plan
- LI, then S-type left shift: program `LI 5` (9'h005), `S left 3` (9'h198), `HALT` (9'h060) → `acc_q` = 8'h28; `done` rises 12 cycles after the first FETCH; `cycle_cnt` = 12 with the macro defined.
- C-type subtract and zero flag: R1 = 8'h07; `LI 7`, `C op 0101 R1` (9'h129), `B +2` (9'h082) → branch taken; `pc` goes 2 → 4; `zflag` = 1.
- Store: `LI 3`, `ST R6` (9'h026) → exactly one cycle with `rf_we` = 1, `rf_waddr` = 6, `rf_wdata` = 8'h03.
- Branch wrap-around: at `pc` = 0, `zflag` = 1, `B -1` (9'h0FF) → `pc` = 8'hFF.
- Reset and `start` during a run: `reset` pulsed in the WB of an ST → `rf_we` stays 0 and the block is in IDLE next cycle with all outputs at reset values. Separately, `start` asserted mid-program → ignored.
- Restart: `start` while in HALT → `done` falls the next cycle, `pc` = 0, `acc_q` = 0, and the program re-executes identically.
